clk_div_ramp: RTL and testbench
===============================

Name: clk_div_ramp

Overview:
Upstream controller for the clock divider. It accepts a target divide value over a valid/ready handshake and walks the divider's div_i input toward the target one step at a time. Each step is held for a fixed dwell period, so the divided clock never changes frequency abruptly. When the target is reached and has settled, the block pulses done_o. All logic runs in the clk_i domain.

Parameters:
DIV_WIDTH, 4, width of divide value; must match the downstream divider.
STEP_CYCLES, 16, clk_i cycles per step and for the final settle; legal range >= 1.
RESET_DIV, 0, value driven on div_o while in reset and after reset; must fit in DIV_WIDTH.

Ports:
clk_i  input  1  clock.
arst_ni  input  1  asynchronous reset, active low.
tgt_div_i  input  DIV_WIDTH  requested divide value.
tgt_valid_i  input  1  request valid; held with stable tgt_div_i until accepted.
tgt_ready_o  output  1  high only in IDLE; a request is accepted on the edge where valid and ready are both high.
abort_i  input  1  stop ramping and hold the current div_o.
div_o  output  DIV_WIDTH  drives div_i of the downstream divider; registered.
busy_o  output  1  high in RAMP or SETTLE.
done_o  output  1  one-cycle pulse when a request completes.

Behaviour:
- Reset is asynchronous, active low. Outputs during and after reset: div_o=RESET_DIV, state=IDLE, tgt_ready_o=1, busy_o=0, done_o=0, dwell counter=0, target register=RESET_DIV.
- Reset asserted mid-ramp: div_o returns to RESET_DIV immediately; no done_o pulse.
- States: IDLE, RAMP, SETTLE, encoded as a 2-bit enum.
- IDLE, request accepted at edge E0, target latched:
  - If tgt_div_i == div_o: stay in IDLE; done_o=1 for the cycle after E0.
  - Otherwise: go to RAMP with the dwell counter at 0.
- RAMP:
  - The counter increments every cycle.
  - On the edge where counter == STEP_CYCLES-1: div_o moves by +1 or -1 toward the target (unsigned compare), and the counter clears.
  - The edge that makes div_o equal the target also moves the state to SETTLE with the counter at 0.
- SETTLE:
  - The counter increments every cycle.
  - On the edge where counter == STEP_CYCLES-1: go to IDLE and set done_o=1 for one cycle.
- Timing for distance d = |target - div_o|, with S = STEP_CYCLES:
  - div_o changes at edges E0+S, E0+2S, ..., E0+d*S.
  - done_o is high in the cycle after edge E0+(d+1)*S.
  - tgt_ready_o goes high at that same edge.
- div_o changes by at most 1 per step and never overshoots; it cannot wrap. Steps between 0 and 2^DIV_WIDTH-1 are legal in both directions.
- STEP_CYCLES == 1: one step per cycle; the counter is effectively constant 0. The counter width is max(1, $clog2(STEP_CYCLES)).
- abort_i:
  - In RAMP or SETTLE: go to IDLE on the next edge, div_o frozen at its current value, no done_o.
  - abort_i on the same edge as a step: abort wins and no step is taken.
  - In IDLE: no effect. A request accepted on the same edge is still taken.
- tgt_valid_i while busy: not accepted. The requester must hold it; it is accepted on the first IDLE cycle.
- done_o and a new acceptance may occur in the same cycle, because ready is high once the block is back in IDLE.

Decomposition:
- Package clk_div_pkg holds:
  - typedef enum logic [1:0] ramp_state_e {IDLE, RAMP, SETTLE}.
  - A shared DIV_WIDTH default constant, used by both this block and the divider.
- No sub-module: the dwell counter and the FSM stay in one module. A top-level pairing with the clock divider is left to the integrator.

Test Plan:
- Reset with RESET_DIV=0, STEP_CYCLES=4, then request 3 at E0 -> div_o=1 at E0+4, 2 at E0+8, 3 at E0+12; done_o pulse after E0+16; busy_o high from E0 to E0+16.
- From div_o=5, request 2 (S=4) -> div_o 4, 3, 2 at E0+4, +8, +12; done_o after E0+16; no overshoot below 2.
- Request equal to current div_o -> done_o in the cycle after acceptance; busy_o stays 0; div_o unchanged.
- Ramp 0->15 with abort_i on the step edge at E0+8 (S=4) -> div_o stays 1; state IDLE; no done_o; tgt_ready_o=1.
- tgt_valid_i held during a ramp with a second target -> not accepted until IDLE; accepted on the done_o cycle; the new ramp starts from the completed value.
- arst_ni pulsed low mid-ramp with div_o=2 -> div_o=RESET_DIV asynchronously; busy_o=0, done_o=0; STEP_CYCLES=1 regression: 0->3 completes with done_o after E0+4.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock divider and its upstream ramp controller.
package clk_div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/clk_div_ramp.sv
// Walks the divider's div value toward a requested target one step per dwell
// period, then waits one more dwell period before pulsing done_o.
module clk_div_ramp
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int unsigned STEP_CYCLES = 16,
  parameter int unsigned RESET_DIV   = 0
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic [DIV_WIDTH-1:0] tgt_div_i,
  input  logic                 tgt_valid_i,
  output logic                 tgt_ready_o,
  input  logic                 abort_i,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);

  localparam int unsigned          CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  ramp_state_e          r_state;
  ramp_state_e          w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_tgt;
  logic [DIV_WIDTH-1:0] w_tgt_nxt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic [DIV_WIDTH-1:0] w_div_step;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_cnt_last;

  // Handshake: a request transfers on the clk_i edge where tgt_valid_i and
  // tgt_ready_o are both high; ready is high exactly while in IDLE, so a
  // requester holding valid during a ramp is taken on the first IDLE cycle.
  assign tgt_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state == RAMP) || (r_state == SETTLE);
  assign done_o      = r_done;
  assign div_o       = r_div;
  assign state_o     = r_state;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_div_step = (r_tgt > r_div) ? (r_div + DIV_ONE) : (r_div - DIV_ONE);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tgt   <= DIV_RST;
      r_div   <= DIV_RST;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tgt   <= w_tgt_nxt;
      r_div   <= w_div_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    w_div_nxt   = r_div;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (tgt_valid_i) begin
          w_tgt_nxt = tgt_div_i;
          w_cnt_nxt = '0;
          if (tgt_div_i == r_div) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = RAMP;
          end
        end
      end
      RAMP: begin
        // Abort has priority over a step falling on the same edge.
        if (abort_i) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_last) begin
          w_div_nxt = w_div_step;
          w_cnt_nxt = '0;
          if (w_div_step == r_tgt) begin
            w_state_nxt = SETTLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      SETTLE: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_div_ramp.sv
// Scoreboard bench for clk_div_ramp: two instances (dwell 4 and dwell 1) driven
// one after the other, div_o steps and done_o pulses checked against a timeline model.
module tb_clk_div_ramp;

  localparam int W        = 4;
  localparam int S0       = 4;
  localparam int S1       = 1;
  localparam int WAIT_MAX = 400;
  localparam int AB_NONE  = -1;
  localparam int AB_RAND  = -2;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic         clk = 1'b0;
  logic         arst_ni = 1'b0;
  logic [W-1:0] tgt0, tgt1;
  logic         v0, v1, a0, a1;
  logic         rdy0, rdy1, busy0, busy1, done0, done1;
  logic [W-1:0] div0, div1;
  logic [1:0]   st0, st1;

  clk_div_ramp #(.DIV_WIDTH(W), .STEP_CYCLES(S0), .RESET_DIV(0)) u_dut0 (
    .clk_i(clk), .arst_ni(arst_ni), .tgt_div_i(tgt0), .tgt_valid_i(v0),
    .tgt_ready_o(rdy0), .abort_i(a0), .div_o(div0), .busy_o(busy0),
    .done_o(done0), .state_o(st0)
  );

  clk_div_ramp #(.DIV_WIDTH(W), .STEP_CYCLES(S1), .RESET_DIV(0)) u_dut1 (
    .clk_i(clk), .arst_ni(arst_ni), .tgt_div_i(tgt1), .tgt_valid_i(v1),
    .tgt_ready_o(rdy1), .abort_i(a1), .div_o(div1), .busy_o(busy1),
    .done_o(done1), .state_o(st1)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  typedef struct packed {
    logic         inst;
    logic [31:0]  cyc;
    logic [W-1:0] val;
  } ev_t;

  ev_t          exp_div_q[$];
  ev_t          exp_done_q[$];
  int           checks = 0;
  int           errors = 0;
  int           model_div[2];
  logic [W-1:0] prev_div[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_inst(input int inst, input logic [W-1:0] d, input logic dn);
    ev_t e;
    if (d !== prev_div[inst]) begin
      if (exp_div_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL div_unexpected: inst %0d got %0d expected no change (cycle %0d)", inst, d, cyc);
      end else begin
        e = exp_div_q.pop_front();
        check("div_inst", inst, int'(e.inst));
        check("div_cycle", cyc, int'(e.cyc));
        check("div_value", int'(d), int'(e.val));
      end
      prev_div[inst] = d;
    end
    if (dn) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: inst %0d got pulse expected none (cycle %0d)", inst, cyc);
      end else begin
        e = exp_done_q.pop_front();
        check("done_inst", inst, int'(e.inst));
        check("done_cycle", cyc, int'(e.cyc));
        check("done_div", int'(d), int'(e.val));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!arst_ni) begin
        prev_div[0] = div0;
        prev_div[1] = div1;
      end else begin
        mon_inst(0, div0, done0);
        mon_inst(1, div1, done1);
        check("ready_vs_busy0", int'(rdy0), int'(!busy0));
        check("ready_vs_busy1", int'(rdy1), int'(!busy1));
      end
    end
  end

  // driver: issue one request, push its expected timeline, optionally abort
  task automatic issue(input int inst, input int tgt, input int ab_mode, output int e0);
    int  cur, d, s, steps, ab;
    bit  got, aborting;
    ev_t e;
    s  = (inst == 1) ? S1 : S0;
    e0 = -1;
    @(negedge clk);
    if (inst == 1) begin v1 = 1'b1; tgt1 = W'(tgt); end
    else begin v0 = 1'b1; tgt0 = W'(tgt); end
    got = 1'b0;
    for (int w = 0; w < WAIT_MAX; w++) begin
      if (((inst == 1) ? rdy1 : rdy0) == 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: inst %0d not ready within %0d cycles expected ready", inst, WAIT_MAX);
      v0 = 1'b0;
      v1 = 1'b0;
      return;
    end
    cur = model_div[inst];
    d   = (tgt > cur) ? tgt - cur : cur - tgt;
    ab  = ab_mode;
    if (ab == AB_RAND) ab = (d > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, (d + 1) * s)) : AB_NONE;
    aborting = (ab > 0) && (d > 0);
    steps    = aborting ? (((ab - 1) / s < d) ? (ab - 1) / s : d) : d;
    e0 = cyc + 1;
    for (int k = 1; k <= steps; k++) begin
      e.inst = inst[0];
      e.cyc  = 32'(e0 + k * s);
      e.val  = W'((tgt > cur) ? cur + k : cur - k);
      exp_div_q.push_back(e);
    end
    if (!aborting) begin
      e.inst = inst[0];
      e.cyc  = 32'((d == 0) ? e0 : e0 + (d + 1) * s);
      e.val  = W'(tgt);
      exp_done_q.push_back(e);
    end
    model_div[inst] = (tgt > cur) ? cur + steps : cur - steps;
    if (ab == 0) begin
      if (inst == 1) a1 = 1'b1; else a0 = 1'b1;
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; a0 = 1'b0; a1 = 1'b0;
    check("busy_after_accept", int'((inst == 1) ? busy1 : busy0), int'(d > 0));
    if (ab > 0) begin
      while (cyc < e0 + ab - 1) @(negedge clk);
      if (inst == 1) a1 = 1'b1; else a0 = 1'b1;
      @(negedge clk);
      a0 = 1'b0; a1 = 1'b0;
      if (aborting) begin
        check("abort_state", int'((inst == 1) ? st1 : st0), int'(ST_IDLE));
        check("abort_ready", int'((inst == 1) ? rdy1 : rdy0), 1);
        check("abort_div", int'((inst == 1) ? div1 : div0), model_div[inst]);
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_div_q.size() != 0 || exp_done_q.size() != 0) && w < WAIT_MAX) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (exp_div_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d div and %0d done events outstanding expected 0",
               exp_div_q.size(), exp_done_q.size());
      exp_div_q.delete();
      exp_done_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // main sequence
  initial begin
    int e0;
    v0 = 1'b0; v1 = 1'b0; a0 = 1'b0; a1 = 1'b0;
    tgt0 = '0; tgt1 = '0;
    model_div[0] = 0; model_div[1] = 0;
    prev_div[0] = '0; prev_div[1] = '0;

    repeat (2) @(negedge clk);
    check("rst_div", int'(div0), 0);
    check("rst_ready", int'(rdy0), 1);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_state", int'(st0), int'(ST_IDLE));
    check("rst_div1", int'(div1), 0);
    #2 arst_ni = 1'b1;
    @(negedge clk);
    check("post_rst_div", int'(div0), 0);
    check("post_rst_state", int'(st0), int'(ST_IDLE));

    issue(0, 3, AB_NONE, e0);  drain();
    issue(0, 5, AB_NONE, e0);  drain();
    issue(0, 2, AB_NONE, e0);  drain();
    issue(0, 2, AB_NONE, e0);  drain();
    issue(0, 0, AB_NONE, e0);  drain();
    issue(0, 15, 8, e0);       drain();
    issue(0, 0, 0, e0);        drain();
    issue(0, 6, AB_NONE, e0);
    issue(0, 9, AB_NONE, e0);  drain();
    issue(0, 0, AB_NONE, e0);
    issue(0, 15, AB_NONE, e0); drain();

    for (int i = 0; i < 12; i++) issue(0, int'($urandom_range(0, 15)), AB_RAND, e0);
    drain();

    issue(0, 0, AB_NONE, e0);  drain();
    issue(0, 15, AB_NONE, e0);
    while (cyc < e0 + 2 * S0) @(negedge clk);
    check("pre_reset_div", int'(div0), 2);
    #2 arst_ni = 1'b0;
    #1;
    check("async_rst_div", int'(div0), 0);
    check("async_rst_busy", int'(busy0), 0);
    check("async_rst_done", int'(done0), 0);
    check("async_rst_ready", int'(rdy0), 1);
    exp_div_q.delete();
    exp_done_q.delete();
    model_div[0] = 0;
    model_div[1] = 0;
    @(negedge clk);
    #2 arst_ni = 1'b1;
    repeat (3 * S0) @(negedge clk);

    issue(1, 3, AB_NONE, e0);  drain();
    issue(1, 3, AB_NONE, e0);  drain();
    issue(1, 12, 3, e0);       drain();
    issue(1, 0, AB_NONE, e0);
    for (int i = 0; i < 8; i++) issue(1, int'($urandom_range(0, 15)), AB_RAND, e0);
    drain();

    check("final_div_q_empty", exp_div_q.size(), 0);
    check("final_done_q_empty", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
